// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the pipelined ALU: opcode encodings,
//                FSM state encoding, result-flag bundle and the signed
//                overflow helper used by the add/subtract family.
//  Macros      : ALU_PIPE_MUL_EN (selects whether OP_MUL is implemented)
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcodes 0-7 keep the legacy 4-bit ALU encoding.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_DEC = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ADC = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;

    // Control FSM encoding (BUSY only reachable when the multiplier is built).
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
        logic illegal;
    } alu_flags_t;

    // Two's-complement overflow of r = x + y, given the sign bits. For a
    // subtraction pass the inverted sign of the subtrahend.
    function automatic logic add_ovf(input logic x_msb, input logic y_msb,
                                     input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Radix-2 shift-add multiplier, one multiplier bit per cycle,
//                WIDTH cycles per product.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                start_i    latch a_i/b_i and begin a new product
//                a_i, b_i   operands (WIDTH bits, unsigned)
//                done_o     high during the final step cycle
//                product_o  2*WIDTH-bit product, valid while done_o is high
//  Macros      : compiled into alu_pipe only under ALU_PIPE_MUL_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand_q;
    logic [WIDTH-1:0]   r_mplier_q;
    logic [2*WIDTH-1:0] r_acc_q;
    logic [CW-1:0]      r_cnt_q;
    logic               r_busy_q;
    logic [2*WIDTH-1:0] w_acc_d;

    // The product is exposed combinationally on the last step so the caller
    // can register it on the same edge that finishes the final step.
    assign w_acc_d   = r_acc_q + (r_mplier_q[0] ? r_mcand_q : '0);
    assign done_o    = r_busy_q && (r_cnt_q == CW'(1));
    assign product_o = w_acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_acc_q    <= '0;
            r_cnt_q    <= '0;
            r_busy_q   <= 1'b0;
        end else if (start_i) begin
            r_mcand_q  <= {{WIDTH{1'b0}}, a_i};
            r_mplier_q <= b_i;
            r_acc_q    <= '0;
            r_cnt_q    <= CW'(WIDTH);
            r_busy_q   <= 1'b1;
        end else if (r_busy_q) begin
            r_acc_q    <= w_acc_d;
            r_mcand_q  <= r_mcand_q << 1;
            r_mplier_q <= r_mplier_q >> 1;
            r_cnt_q    <= r_cnt_q - CW'(1);
            if (r_cnt_q == CW'(1)) begin
                r_busy_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Registered WIDTH-bit ALU with valid/ready handshakes on both
//                sides and a single-entry output register. Single-cycle ops
//                have latency 1; MUL (optional) takes WIDTH+1 cycles.
//  Ports       : clk, rst_n            clock, async active-low reset
//                in_valid / in_ready   operation handshake
//                a, b, opcode          operands and operation select
//                out_valid / out_ready result handshake
//                f                     result
//                carry_out, zero, negative, overflow, illegal  result flags
//  Macros      : ALU_PIPE_MUL_EN - when defined, opcode 11 is a multi-cycle
//                shift-add multiply; otherwise it is a reserved opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);

    // ------------------------------------------------------------------
    // Registered result
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_f_q;
    logic             r_carry_q;
    logic             r_ovf_q;
    logic             r_illegal_q;
    logic             r_cflag_q;
    logic             r_out_valid_q;

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    logic w_idle;
    logic w_accept;
    logic w_is_mul;
    logic w_load;
    logic w_mul_done;
    logic [WIDTH-1:0] w_mul_f;
    logic w_mul_carry;

    assign in_ready = w_idle && (!r_out_valid_q || out_ready);
    assign w_accept = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    state_t             r_state_q;
    state_t             w_state_d;
    logic [2*WIDTH-1:0] w_product;

    assign w_is_mul = (opcode == OP_MUL);
    assign w_idle   = (r_state_q == ST_IDLE);

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (w_accept && w_is_mul),
        .a_i      (a),
        .b_i      (b),
        .done_o   (w_mul_done),
        .product_o(w_product)
    );

    assign w_mul_f     = w_product[WIDTH-1:0];
    assign w_mul_carry = |w_product[2*WIDTH-1:WIDTH];

    always_comb begin
        w_state_d = r_state_q;
        if (r_state_q == ST_IDLE) begin
            if (w_accept && w_is_mul) begin
                w_state_d = ST_BUSY;
            end
        end else if (w_mul_done) begin
            w_state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end
`else
    // Without the multiplier there is no BUSY state: every op is one cycle.
    assign w_is_mul    = 1'b0;
    assign w_idle      = 1'b1;
    assign w_mul_done  = 1'b0;
    assign w_mul_f     = '0;
    assign w_mul_carry = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH:0]   w_adc;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [WIDTH-1:0] w_alu_f;
    logic             w_alu_carry;
    logic             w_alu_ovf;
    logic             w_alu_illegal;

    assign w_shamt = b[SHW-1:0];
    // Zero-extended (WIDTH+1)-bit arithmetic: bit WIDTH is carry or borrow.
    assign w_add   = {1'b0, a} + {1'b0, b};
    assign w_sub   = {1'b0, a} - {1'b0, b};
    assign w_inc   = {1'b0, a} + c_one;
    assign w_dec   = {1'b0, a} - c_one;
    assign w_adc   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, r_cflag_q};
    // One guard bit beside the operand catches the last bit shifted out;
    // with a zero amount the guard is still zero so carry reads 0.
    assign w_shl   = {1'b0, a} << w_shamt;
    assign w_shr   = {a, 1'b0} >> w_shamt;

    always_comb begin
        w_alu_f       = '0;
        w_alu_carry   = 1'b0;
        w_alu_ovf     = 1'b0;
        w_alu_illegal = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_alu_f     = w_add[WIDTH-1:0];
                w_alu_carry = w_add[WIDTH];
                w_alu_ovf   = add_ovf(a[MSB], b[MSB], w_add[MSB]);
            end
            OP_SUB: begin
                w_alu_f     = w_sub[WIDTH-1:0];
                w_alu_carry = w_sub[WIDTH];
                w_alu_ovf   = add_ovf(a[MSB], ~b[MSB], w_sub[MSB]);
            end
            OP_AND: w_alu_f = a & b;
            OP_OR:  w_alu_f = a | b;
            OP_XOR: w_alu_f = a ^ b;
            OP_NOT: w_alu_f = ~a;
            OP_INC: begin
                w_alu_f     = w_inc[WIDTH-1:0];
                w_alu_carry = w_inc[WIDTH];
                w_alu_ovf   = add_ovf(a[MSB], 1'b0, w_inc[MSB]);
            end
            OP_DEC: begin
                w_alu_f     = w_dec[WIDTH-1:0];
                w_alu_carry = w_dec[WIDTH];
                w_alu_ovf   = add_ovf(a[MSB], 1'b1, w_dec[MSB]);
            end
            OP_SHL: begin
                w_alu_f     = w_shl[WIDTH-1:0];
                w_alu_carry = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_alu_f     = w_shr[WIDTH:1];
                w_alu_carry = w_shr[0];
            end
            OP_ADC: begin
                w_alu_f     = w_adc[WIDTH-1:0];
                w_alu_carry = w_adc[WIDTH];
                w_alu_ovf   = add_ovf(a[MSB], b[MSB], w_adc[MSB]);
            end
            // Reserved opcodes (and MUL when the multiplier is absent; when
            // present, MUL never loads from this path).
            default: w_alu_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register: load on a completed op, otherwise drain on out_ready.
    // A drain and a new load on the same edge simply overwrite the entry.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_f_d;
    logic             w_carry_d;
    logic             w_ovf_d;
    logic             w_illegal_d;

    assign w_load      = (w_accept && !w_is_mul) || w_mul_done;
    assign w_f_d       = w_mul_done ? w_mul_f     : w_alu_f;
    assign w_carry_d   = w_mul_done ? w_mul_carry : w_alu_carry;
    assign w_ovf_d     = w_mul_done ? 1'b0        : w_alu_ovf;
    assign w_illegal_d = w_mul_done ? 1'b0        : w_alu_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_q         <= '0;
            r_carry_q     <= 1'b0;
            r_ovf_q       <= 1'b0;
            r_illegal_q   <= 1'b0;
            r_cflag_q     <= 1'b0;
            r_out_valid_q <= 1'b0;
        end else if (w_load) begin
            r_f_q         <= w_f_d;
            r_carry_q     <= w_carry_d;
            r_ovf_q       <= w_ovf_d;
            r_illegal_q   <= w_illegal_d;
            r_cflag_q     <= w_carry_d;
            r_out_valid_q <= 1'b1;
        end else if (out_ready) begin
            r_out_valid_q <= 1'b0;
        end
    end

    // zero/negative always follow the registered result.
    alu_flags_t w_flags;

    assign w_flags.carry    = r_carry_q;
    assign w_flags.zero     = (r_f_q == '0);
    assign w_flags.negative = r_f_q[MSB];
    assign w_flags.overflow = r_ovf_q;
    assign w_flags.illegal  = r_illegal_q;

    assign out_valid = r_out_valid_q;
    assign f         = r_f_q;
    assign carry_out = w_flags.carry;
    assign zero      = w_flags.zero;
    assign negative  = w_flags.negative;
    assign overflow  = w_flags.overflow;
    assign illegal   = w_flags.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed self-checking bench for alu_pipe at WIDTH=8.
//                Follows ALU_PIPE_MUL_EN to pick MUL or reserved behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] opcode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] f;
    logic       carry_out;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       illegal;

    int total = 0;
    int bad   = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .f        (f),
        .carry_out(carry_out),
        .zero     (zero),
        .negative (negative),
        .overflow (overflow),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, confirm it is acceptable, and clock it in.
    task automatic issue(input string tag, input logic [3:0] op,
                         input logic [7:0] aa, input logic [7:0] bb);
        opcode   = op;
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [7:0] ef,
                              input logic ec, input logic ez, input logic en,
                              input logic eo, input logic ei);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_f"},     f,         ef);
        chk({tag, "_carry"}, carry_out, ec);
        chk({tag, "_zero"},  zero,      ez);
        chk({tag, "_neg"},   negative,  en);
        chk({tag, "_ovf"},   overflow,  eo);
        chk({tag, "_ill"},   illegal,   ei);
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_f"},     f,         0);
        chk({tag, "_flags"}, {carry_out, zero, negative, overflow, illegal}, 5'b01000);
    endtask

    logic [7:0] res [8];
    int         nres;
    int         idx;
    int         hold_left;
    logic       first_seen;
    logic       acc;
    logic [7:0] held_f;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        opcode    = OP_ADD;

        // ---------------- reset state ----------------
        step(); step(); step();
        rst_n = 1'b1;
        #1;
        // zero is derived from f, so it reads 1 while f is 0.
        expect_reset("rst");
        chk("rst_in_ready", in_ready, 1);

        // ---------------- arithmetic flags ----------------
        issue("add", OP_ADD, 8'hF0, 8'h20);
        expect_res("add", 8'h10, 1, 0, 0, 0, 0);
        issue("sub", OP_SUB, 8'h05, 8'h07);
        expect_res("sub", 8'hFE, 1, 0, 1, 0, 0);
        issue("inc", OP_INC, 8'h7F, 8'h00);
        expect_res("inc", 8'h80, 0, 0, 1, 1, 0);
        issue("dec", OP_DEC, 8'h00, 8'h00);
        expect_res("dec", 8'hFF, 1, 0, 1, 0, 0);
        step();
        chk("drain_valid", out_valid, 0);
        chk("drain_hold_f", f, 8'hFF);

        // ---------------- logic ops ----------------
        issue("and", OP_AND, 8'hF0, 8'h3C);
        expect_res("and", 8'h30, 0, 0, 0, 0, 0);
        issue("xor", OP_XOR, 8'hFF, 8'h0F);
        expect_res("xor", 8'hF0, 0, 0, 1, 0, 0);
        issue("not", OP_NOT, 8'h55, 8'h00);
        expect_res("not", 8'hAA, 0, 0, 1, 0, 0);

        // ---------------- ADC chain ----------------
        issue("addc", OP_ADD, 8'hFF, 8'h01);
        expect_res("addc", 8'h00, 1, 1, 0, 0, 0);
        issue("adc", OP_ADC, 8'h00, 8'h00);
        expect_res("adc", 8'h01, 0, 0, 0, 0, 0);

        // ---------------- shifts / reserved ----------------
        issue("shl1", OP_SHL, 8'h81, 8'h01);
        expect_res("shl1", 8'h02, 1, 0, 0, 0, 0);
        issue("shr0", OP_SHR, 8'h81, 8'h00);
        expect_res("shr0", 8'h81, 0, 0, 1, 0, 0);
        issue("shr7", OP_SHR, 8'h81, 8'h07);
        expect_res("shr7", 8'h01, 0, 0, 0, 0, 0);
        issue("resD", 4'hD, 8'h12, 8'h34);
        expect_res("resD", 8'h00, 0, 1, 0, 0, 1);
        issue("clrill", OP_OR, 8'hF0, 8'h0F);
        expect_res("clrill", 8'hFF, 0, 0, 1, 0, 0);

        // ---------------- multiply ----------------
`ifdef ALU_PIPE_MUL_EN
        issue("mul1", OP_MUL, 8'h0F, 8'h11);
        chk("mul1_busy_ready", in_ready, 0);
        chk("mul1_busy_valid", out_valid, 0);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("mul1_wait_ready", in_ready, 0);
            chk("mul1_wait_valid", out_valid, 0);
        end
        step();
        expect_res("mul1", 8'hFF, 0, 0, 1, 0, 0);
        chk("mul1_done_ready", in_ready, 1);

        issue("mul2", OP_MUL, 8'h10, 8'h10);
        for (int i = 1; i < 8; i++) step();
        chk("mul2_early", out_valid, 0);
        step();
        expect_res("mul2", 8'h00, 1, 1, 0, 0, 0);
`else
        issue("mulrsv", OP_MUL, 8'h0F, 8'h11);
        expect_res("mulrsv", 8'h00, 0, 1, 0, 0, 1);
`endif

        // ---------------- backpressure ----------------
        nres       = 0;
        idx        = 0;
        hold_left  = 0;
        first_seen = 1'b0;
        held_f     = 8'h00;
        step();
        for (int cyc = 0; cyc < 16; cyc++) begin
            in_valid  = (idx < 4);
            opcode    = OP_ADD;
            a         = 8'(idx + 1);
            b         = 8'(idx + 1);
            out_ready = (hold_left == 0);
            #1;
            if (out_valid && !out_ready) begin
                chk("bp_hold_f", f, held_f);
                chk("bp_hold_ready", in_ready, 0);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (nres < 8) res[nres] = f;
                nres++;
            end
            step();
            if (acc) idx++;
            if (hold_left > 0) hold_left--;
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                hold_left  = 3;
                held_f     = f;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", nres, 4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", res[i], 8'(2 * (i + 1)));
        end

        // ---------------- reset during an in-flight op ----------------
`ifdef ALU_PIPE_MUL_EN
        issue("rmid", OP_MUL, 8'h0F, 8'h11);
        step(); step(); step();
`else
        out_ready = 1'b0;
        issue("rmid", OP_ADD, 8'h03, 8'h04);
        chk("rmid_pending", out_valid, 1);
`endif
        rst_n = 1'b0;
        #1;
        chk("rmid_async_valid", out_valid, 0);
        step(); step(); step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        expect_reset("rmid");
        chk("rmid_in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rmid_no_stale", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
